// File: rtl/fixed_activation_arbiter_pkg.sv
// fixed_activation_arbiter_pkg: FSM state and requester-id tag types shared by the arbiter files
package fixed_activation_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  typedef logic tag_t;
endpackage

// File: rtl/fixed_activation_arbiter_if.sv
// fixed_activation_arbiter_if: two requesters, shared datapath out/in, two return outputs, busy
// slave: arbiter side, master: environment side; every stream is a valid/ready handshake of N-element beats
interface fixed_activation_arbiter_if #(parameter int N = 2, parameter int W = 8);
  logic [W-1:0] data_in_0 [N];
  logic [W-1:0] data_in_1 [N];
  logic data_in_0_valid, data_in_1_valid, data_in_0_ready, data_in_1_ready;
  logic [W-1:0] dp_data_out [N];
  logic dp_data_out_valid, dp_data_out_ready;
  logic [W-1:0] dp_data_in [N];
  logic dp_data_in_valid, dp_data_in_ready;
  logic [W-1:0] data_out_0 [N];
  logic [W-1:0] data_out_1 [N];
  logic data_out_0_valid, data_out_1_valid, data_out_0_ready, data_out_1_ready;
  logic busy;
  modport slave (
    input data_in_0, data_in_1, data_in_0_valid, data_in_1_valid, dp_data_out_ready,
    input dp_data_in, dp_data_in_valid, data_out_0_ready, data_out_1_ready,
    output data_in_0_ready, data_in_1_ready, dp_data_out, dp_data_out_valid, dp_data_in_ready,
    output data_out_0, data_out_1, data_out_0_valid, data_out_1_valid, busy
  );
  modport master (
    output data_in_0, data_in_1, data_in_0_valid, data_in_1_valid, dp_data_out_ready,
    output dp_data_in, dp_data_in_valid, data_out_0_ready, data_out_1_ready,
    input data_in_0_ready, data_in_1_ready, dp_data_out, dp_data_out_valid, dp_data_in_ready,
    input data_out_0, data_out_1, data_out_0_valid, data_out_1_valid, busy
  );
endinterface

// File: rtl/fixed_activation_arbiter_tag_fifo.sv
// arb_tag_fifo: owner-tag queue of tensors granted but not yet fully returned
// ports: i_push/i_tag enqueue, i_pop dequeue (both in one cycle allowed), o_head/o_full/o_empty status
module arb_tag_fifo import fixed_activation_arbiter_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  tag_t i_tag,
  input  logic i_pop,
  output tag_t o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  tag_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head = r_mem[r_rd];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_tag;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/fixed_activation_arbiter.sv
// fixed_activation_arbiter: round-robin, whole-tensor sharing of one activation datapath by two requesters
// ports: clk, rst (async, active high), bus (slave modport: requester inputs, datapath out/in, return outputs, busy)
module fixed_activation_arbiter import fixed_activation_arbiter_pkg::*; #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int TAG_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  fixed_activation_arbiter_if.slave bus
);
  localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                         (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW = $clog2(BEATS + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_send_cnt, r_ret_cnt;
  tag_t r_last_grant, w_win, w_head;
  logic w_full, w_empty, w_push, w_pop, w_g0, w_g1, w_send_hs, w_send_last, w_ret_hs;
  logic [DATA_IN_0_PRECISION_0-1:0] w_fwd [N];
  arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_tag(w_win), .i_pop(w_pop),
    .o_head(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  assign w_g0 = r_state == GRANT0;
  assign w_g1 = r_state == GRANT1;
  assign w_send_hs = (w_g0 ? bus.data_in_0_valid : w_g1 && bus.data_in_1_valid) && bus.dp_data_out_ready;
  assign w_send_last = w_send_hs && r_send_cnt == CW'(BEATS - 1);
  // contention goes to the requester that did not win last time
  assign w_win = bus.data_in_0_valid && bus.data_in_1_valid ? ~r_last_grant : bus.data_in_1_valid;
  assign w_ret_hs = bus.dp_data_in_valid && bus.dp_data_in_ready;
  assign w_pop = w_ret_hs && r_ret_cnt == CW'(BEATS - 1);
  always_comb begin
    // w_full is the registered flag, so a same-cycle pop never frees a slot for this grant
    w_push = r_state == IDLE && (bus.data_in_0_valid || bus.data_in_1_valid) && !w_full;
    w_next = w_push ? (w_win ? GRANT1 : GRANT0) : w_send_last ? IDLE : r_state;
    bus.dp_data_out_valid = w_g0 ? bus.data_in_0_valid : w_g1 && bus.data_in_1_valid;
    bus.data_in_0_ready = w_g0 && bus.dp_data_out_ready;
    bus.data_in_1_ready = w_g1 && bus.dp_data_out_ready;
    bus.data_out_0_valid = !w_empty && !w_head && bus.dp_data_in_valid;
    bus.data_out_1_valid = !w_empty && w_head && bus.dp_data_in_valid;
    bus.dp_data_in_ready = !w_empty && (w_head ? bus.data_out_1_ready : bus.data_out_0_ready);
    bus.busy = r_state != IDLE || !w_empty;
    for (int i = 0; i < N; i++) begin
      w_fwd[i] = w_g1 ? bus.data_in_1[i] : bus.data_in_0[i];
      bus.dp_data_out[i] = w_fwd[i];
      bus.data_out_0[i] = bus.dp_data_in[i];
      bus.data_out_1[i] = bus.dp_data_in[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_send_cnt <= '0;
      r_ret_cnt <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_push) r_last_grant <= w_win;
      if (w_send_hs) r_send_cnt <= w_send_last ? '0 : r_send_cnt + CW'(1);
      if (w_ret_hs) r_ret_cnt <= w_pop ? '0 : r_ret_cnt + CW'(1);
    end
endmodule

// File: doc/fixed_activation_arbiter.md
FIXED_ACTIVATION_ARBITER -- requirements
Module: fixed_activation_arbiter

Interface
REQ-001 The parameter DATA_IN_0_PRECISION_0 SHALL default to 8 and set the element width in bits.
REQ-002 The parameter DATA_IN_0_TENSOR_SIZE_DIM_0 SHALL default to 8 and set the tensor size in dim 0.
REQ-003 The parameter DATA_IN_0_TENSOR_SIZE_DIM_1 SHALL default to 1 and set the tensor size in dim 1.
REQ-004 The parameter DATA_IN_0_PARALLELISM_DIM_0 SHALL default to 2 and set the elements per beat in dim 0 (must divide the dim-0 size).
REQ-005 The parameter DATA_IN_0_PARALLELISM_DIM_1 SHALL default to 1 and set the elements per beat in dim 1 (must divide the dim-1 size).
REQ-006 The parameter TAG_DEPTH SHALL default to 2 and set the number of tensors that may be in flight in the datapath.
REQ-007 Port clk SHALL be a 1-bit input: the single clock.
REQ-008 Port rst SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-009 Ports data_in_0/data_in_1 SHALL be inputs: unpacked arrays of N = P0*P1 elements, each PRECISION_0 bits, one per requester.
REQ-010 Ports data_in_0_valid/data_in_1_valid SHALL be 1-bit inputs, and data_in_0_ready/data_in_1_ready SHALL be 1-bit outputs.
REQ-011 Port dp_data_out SHALL be an N-element output array, with 1-bit dp_data_out_valid (output) and dp_data_out_ready (input), driving the shared activation datapath.
REQ-012 Port dp_data_in SHALL be an N-element input array, with 1-bit dp_data_in_valid (input) and dp_data_in_ready (output), carrying results back from the datapath.
REQ-013 Ports data_out_0/data_out_1 SHALL be N-element output arrays, each with a 1-bit valid output and a 1-bit ready input.
REQ-014 Output busy SHALL be 1 bit, high while any tensor is granted or in flight.

Function
REQ-015 BEATS SHALL equal (T0/P0)*(T1/P1); grants SHALL be whole tensors, never interleaving beats from two requesters.
REQ-016 The FSM SHALL have states IDLE, GRANT0, GRANT1.
REQ-017 From IDLE, the FSM SHALL enter GRANTk when some valid is high and the tag FIFO is not full; if both are valid, the requester not equal to last_grant SHALL win (round robin).
REQ-018 On entering GRANTk, the block SHALL push tag k into the tag FIFO and set last_grant=k in the same edge.
REQ-019 In GRANTk: dp_data_out=data_in_k, dp_data_out_valid=data_in_k_valid, data_in_k_ready=dp_data_out_ready; the other requester's ready SHALL be 0; this forward path SHALL be combinational with zero latency.
REQ-020 The send counter SHALL increment on each dp_data_out handshake; on the handshake with count BEATS-1, it SHALL clear and the FSM SHALL return to IDLE.
REQ-021 In IDLE, all input readies and dp_data_out_valid SHALL be 0.
REQ-022 Return routing: with FIFO head h, data_out_h=dp_data_in, data_out_h_valid=dp_data_in_valid, and dp_data_in_ready=data_out_h_ready; the other output's valid SHALL be 0.
REQ-023 With the FIFO empty, dp_data_in_ready and both output valids SHALL be 0.
REQ-024 The return counter SHALL increment on each dp_data_in handshake; at BEATS-1 it SHALL clear and pop the FIFO head.
REQ-025 A grant push and a last-beat pop in the same cycle SHALL both take effect, with occupancy unchanged; a grant SHALL NOT be issued when the FIFO is full, even if a pop occurs that cycle (no bypass).
REQ-026 With BEATS=1, each grant SHALL last exactly one handshake.
REQ-027 Valid deassertion mid-tensor SHALL stall the grant; the grant SHALL NOT be preempted.
REQ-028 busy SHALL be high when state≠IDLE or the FIFO is non-empty.

Reset
REQ-029 On rst, the block SHALL set state=IDLE, both counters=0, tag FIFO empty, last_grant=1 (requester 0 wins first contention), and all valids/readies and busy=0, asynchronously.
REQ-030 Reset mid-tensor SHALL discard all in-flight tags; no partial-tensor recovery SHALL be provided.

Structure
REQ-031 A shared package SHALL hold the FSM state enum typedef and the requester-id tag typedef.
REQ-032 The tag FIFO SHALL be one sub-module, arb_tag_fifo (width 1, depth TAG_DEPTH, simultaneous push/pop supported).
REQ-033 BEATS and the counter widths ($clog2(BEATS+1)) SHALL be localparams.

Verification
REQ-034 Only requester 0 valid, with 4 beats of 0x10..0x17 through a pass-through datapath, SHALL appear on data_out_0 in order; data_out_1_valid SHALL stay 0.
REQ-035 Both requesters valid from reset SHALL grant 0, then 1, then 0, with tensors unsplit.
REQ-036 A datapath holding dp_data_in_valid low until 2 tensors are sent SHALL block a third grant (FIFO full) until the first tensor fully returns.
REQ-037 dp_data_out_ready toggling every cycle SHALL still deliver all 4 beats per tensor with no duplication or loss.
REQ-038 Asserting rst at beat 2 of tensor 0 SHALL give busy=0 and state IDLE; a fresh tensor afterwards SHALL route to its correct owner.
REQ-039 With BEATS=1 and a last-return pop coinciding with an IDLE grant, the FIFO occupancy SHALL stay correct and tags SHALL not be lost.
